// File: rtl/crc_engine.sv
// crc_engine: bit-serial CRC engine that consumes one data bit per clock.
// A word is accepted in IDLE and then shifted through the CRC register over
// DIN_W cycles in BUSY. Polynomial, preset, output mask and bit order are
// set by parameters.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   din_i        data word, sampled on accept
//   din_valid_i  data word offered
//   din_ready_o  engine can accept a word this cycle (combinational)
//   clear_i      synchronous re-initialise / abort, highest priority
//   crc_rd_i     read-and-clear strobe, honoured in IDLE only
//   busy_o       a word is being processed
//   crc_valid_o  at least one complete word since the last init
//   crc_o        final CRC value (register ^ XOR_OUT, combinational)
//   word_cnt_o   complete words since the last init, saturating
module crc_engine #(
    parameter int unsigned      CRC_W   = 8,
    parameter int unsigned      DIN_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h31),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter bit               REFLECT = 1'b1,
    parameter int unsigned      CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIN_W-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic             clear_i,
    input  logic             crc_rd_i,
    output logic             busy_o,
    output logic             crc_valid_o,
    output logic [CRC_W-1:0] crc_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int unsigned BC_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;

    function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CRC_W); i++) begin
            r[i] = v[int'(CRC_W) - 1 - i];
        end
        return r;
    endfunction

    // In LSB-first mode the register holds the reflected CRC, so the
    // polynomial and the preset are reflected once at elaboration.
    localparam logic [CRC_W-1:0] POLY_R   = bitrev(POLY);
    localparam logic [CRC_W-1:0] INIT_EFF = REFLECT ? bitrev(INIT) : INIT;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DIN_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   crc_step;
    logic [DIN_W-1:0]   sh_q;
    logic [DIN_W-1:0]   sh_step;
    logic [BC_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               crc_valid_q;
    logic               din_bit;
    logic               fb;
    logic               accept;
    logic               last_bit;
    logic               do_init;

    assign accept   = din_valid_i && din_ready_o;
    assign last_bit = (state_q == BUSY) && (bit_cnt_q == LAST_BIT);
    assign do_init  = clear_i || ((state_q == IDLE) && crc_rd_i);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear aborts from any state
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept)   state_d = BUSY;
                BUSY:    if (last_bit) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy_o      = 1'b0;
        din_ready_o = 1'b0;
        if (state_q == BUSY) begin
            busy_o = 1'b1;
        end
        if ((state_q == IDLE) && !clear_i && !crc_rd_i) begin
            din_ready_o = 1'b1;
        end
    end

    // One CRC step for the next data bit in the shift register
    always_comb begin
        din_bit  = 1'b0;
        fb       = 1'b0;
        crc_step = crc_q;
        sh_step  = sh_q;
        if (REFLECT) begin
            din_bit  = sh_q[0];
            fb       = crc_q[0] ^ din_bit;
            crc_step = (crc_q >> 1) ^ (fb ? POLY_R : '0);
            sh_step  = sh_q >> 1;
        end else begin
            din_bit  = sh_q[DIN_W-1];
            fb       = crc_q[CRC_W-1] ^ din_bit;
            crc_step = (crc_q << 1) ^ (fb ? POLY : '0);
            sh_step  = sh_q << 1;
        end
    end

    // Datapath: init, word capture, per-bit update and word accounting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q       <= INIT_EFF;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            crc_valid_q <= 1'b0;
        end else if (do_init) begin
            crc_q       <= INIT_EFF;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            crc_valid_q <= 1'b0;
        end else if (accept) begin
            sh_q      <= din_i;
            bit_cnt_q <= '0;
        end else if (state_q == BUSY) begin
            crc_q     <= crc_step;
            sh_q      <= sh_step;
            bit_cnt_q <= bit_cnt_q + BC_W'(1);
            if (last_bit) begin
                if (word_cnt_q != {CNT_W{1'b1}}) begin
                    word_cnt_q <= word_cnt_q + CNT_W'(1);
                end
                crc_valid_q <= 1'b1;
            end
        end
    end

    assign crc_o       = crc_q ^ XOR_OUT;
    assign word_cnt_o  = word_cnt_q;
    assign crc_valid_o = crc_valid_q;

endmodule

// File: tb/tb_crc_engine.sv
// Testbench for crc_engine: three instances (CRC-8/MAXIM defaults,
// CRC-16/CCITT-FALSE with a 2-bit word counter, CRC-32) share one stimulus
// stream. Accepted words push expected results into a scoreboard; a monitor
// pops and compares whenever a word completes.
module tb_crc_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        clear = 1'b0;
    logic        crc_rd = 1'b0;

    logic        rdy8,  busy8,  v8;
    logic [7:0]  crc8;
    logic [15:0] n8;
    logic        rdy16, busy16, v16;
    logic [15:0] crc16;
    logic [1:0]  n16;
    logic        rdy32, busy32, v32;
    logic [31:0] crc32;
    logic [15:0] n32;

    always #5 clk = ~clk;

    crc_engine u_c8 (
        .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid),
        .din_ready_o(rdy8), .clear_i(clear), .crc_rd_i(crc_rd),
        .busy_o(busy8), .crc_valid_o(v8), .crc_o(crc8), .word_cnt_o(n8)
    );

    crc_engine #(
        .CRC_W(16), .DIN_W(8), .POLY(16'h1021), .INIT(16'hFFFF),
        .XOR_OUT(16'h0000), .REFLECT(1'b0), .CNT_W(2)
    ) u_c16 (
        .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid),
        .din_ready_o(rdy16), .clear_i(clear), .crc_rd_i(crc_rd),
        .busy_o(busy16), .crc_valid_o(v16), .crc_o(crc16), .word_cnt_o(n16)
    );

    crc_engine #(
        .CRC_W(32), .DIN_W(8), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF), .REFLECT(1'b1), .CNT_W(16)
    ) u_c32 (
        .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid),
        .din_ready_o(rdy32), .clear_i(clear), .crc_rd_i(crc_rd),
        .busy_o(busy32), .crc_valid_o(v32), .crc_o(crc32), .word_cnt_o(n32)
    );

    typedef struct {
        logic [7:0]  c8;
        logic [15:0] c16;
        logic [31:0] c32;
        logic [15:0] n8;
        logic [1:0]  n16;
        logic [15:0] n32;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  hist[$];
    int          checks = 0;
    int          errors = 0;
    time         acc_t;
    time         prev_acc_t;
    time         ref_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = v[i];
        return r;
    endfunction

    // Textbook byte-wise CRC over every byte since the last init.
    function automatic logic [31:0] crc_ref(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xo,
                                            input bit refl);
        logic [31:0] mask;
        logic [31:0] c;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        if (refl) begin
            c = rev(init, w);
            foreach (hist[k]) begin
                c = c ^ 32'(hist[k]);
                for (int b = 0; b < 8; b++)
                    c = c[0] ? ((c >> 1) ^ rev(poly, w)) : (c >> 1);
            end
        end else begin
            c = init & mask;
            foreach (hist[k]) begin
                c = c ^ (32'(hist[k]) << (w - 8));
                for (int b = 0; b < 8; b++)
                    c = c[w-1] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
            end
        end
        return (c ^ xo) & mask;
    endfunction

    function automatic exp_t model_now();
        exp_t e;
        int   n;
        n     = hist.size();
        e.c8  = 8'(crc_ref(8, 32'h31, 32'h0, 32'h0, 1'b1));
        e.c16 = 16'(crc_ref(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0));
        e.c32 = crc_ref(32, 32'h04C11DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        e.n8  = 16'(n);
        e.n16 = (n > 3) ? 2'd3 : 2'(n);
        e.n32 = 16'(n);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and wait for the accepting edge; on accept the expected
    // completion result is pushed to the scoreboard.
    task automatic send(input logic [7:0] b, input bit keep);
        bit acc;
        int n;
        din       = b;
        din_valid = 1'b1;
        n         = 0;
        acc       = 1'b0;
        while (!acc) begin
            #1;
            acc = rdy8;
            @(posedge clk);
            if (!acc) begin
                n++;
                if (n > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got no ready expected ready within 100 cycles");
                    din_valid = 1'b0;
                    return;
                end
            end
        end
        prev_acc_t = acc_t;
        acc_t      = $time;
        hist.push_back(b);
        sb.push_back(model_now());
        #1;
        din_valid = keep;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy8) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy expected idle within 60 cycles");
    endtask

    task automatic chk_init(input string tag);
        chk({tag, "_busy"},  32'(busy8), 32'h0);
        chk({tag, "_crc8"},  32'(crc8),  32'h00);
        chk({tag, "_crc16"}, 32'(crc16), 32'hFFFF);
        chk({tag, "_crc32"}, crc32,      32'h0);
        chk({tag, "_n8"},    32'(n8),    32'h0);
        chk({tag, "_n16"},   32'(n16),   32'h0);
        chk({tag, "_v8"},    32'(v8),    32'h0);
        chk({tag, "_v32"},   32'(v32),   32'h0);
    endtask

    // Monitor: a completion is BUSY falling without clear or reset behind it.
    bit prev_busy  = 1'b0;
    bit prev_clear = 1'b0;
    bit prev_rst   = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (prev_busy && !busy8 && !prev_clear && !prev_rst && !rst) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("mon_crc8",   32'(crc8),   32'(e.c8));
                chk("mon_crc16",  32'(crc16),  32'(e.c16));
                chk("mon_crc32",  crc32,       e.c32);
                chk("mon_n8",     32'(n8),     32'(e.n8));
                chk("mon_n16",    32'(n16),    32'(e.n16));
                chk("mon_n32",    32'(n32),    32'(e.n32));
                chk("mon_v8",     32'(v8),     32'h1);
                chk("mon_v16",    32'(v16),    32'h1);
                chk("mon_v32",    32'(v32),    32'h1);
                chk("mon_busy16", 32'(busy16), 32'h0);
                chk("mon_busy32", 32'(busy32), 32'h0);
            end
        end
        prev_busy  = busy8;
        prev_clear = clear;
        prev_rst   = rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         r;
        int         op;
        exp_t       e;

        // Reset values while rst is held, across clock edges
        #12;
        chk_init("rst");
        chk("rst_rdy8",  32'(rdy8),  32'h1);
        chk("rst_rdy16", 32'(rdy16), 32'h1);
        chk("rst_rdy32", 32'(rdy32), 32'h1);

        // First accept on the first rising edge after release
        @(negedge clk);
        #1;
        rst   = 1'b0;
        ref_t = $time;
        send(8'h5A, 1'b0);
        chk("first_accept_gap", 32'(acc_t - ref_t), 32'd4);
        wait_idle();

        // Clear on the 3rd BUSY cycle of a word discards it
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        hist.delete();
        send(8'h31, 1'b0);
        repeat (2) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        void'(sb.pop_back());
        hist.delete();
        chk_init("abort");

        // "123456789" streamed back-to-back
        for (int i = 0; i < 9; i++) begin
            send(8'h31 + 8'(i), i < 8);
            if (i > 0) chk("b2b_gap", 32'(acc_t - prev_acc_t), 32'd90);
        end
        wait_idle();
        chk("kv_crc8",  32'(crc8),  32'hA1);
        chk("kv_crc16", 32'(crc16), 32'h29B1);
        chk("kv_crc32", crc32,      32'hCBF4_3926);
        chk("kv_n8",    32'(n8),    32'd9);
        chk("kv_n16",   32'(n16),   32'd3);
        chk("kv_v8",    32'(v8),    32'h1);

        // Read strobe together with valid: not ready, init, accept next edge
        @(posedge clk);
        #1;
        b         = 8'($urandom);
        din       = b;
        din_valid = 1'b1;
        crc_rd    = 1'b1;
        #1;
        e = model_now();
        chk("rdv_rdy8",  32'(rdy8),  32'h0);
        chk("rdv_rdy32", 32'(rdy32), 32'h0);
        chk("rdv_crc8",  32'(crc8),  32'(e.c8));
        @(posedge clk);
        ref_t = $time;
        #1;
        hist.delete();
        chk_init("rdv");
        crc_rd = 1'b0;
        send(b, 1'b0);
        chk("rdv_accept_gap", 32'(acc_t - ref_t), 32'd10);

        // Randomised mix of words, read strobes and aborts
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 9));
            if (op < 6) begin
                send(8'($urandom), 1'b0);
                repeat ($urandom_range(0, 2)) step();
            end else if (op < 8) begin
                wait_idle();
                @(posedge clk);
                #1;
                crc_rd = 1'b1;
                #1;
                e = model_now();
                chk("rd_crc8",  32'(crc8),  32'(e.c8));
                chk("rd_crc16", 32'(crc16), 32'(e.c16));
                chk("rd_crc32", crc32,      e.c32);
                step();
                crc_rd = 1'b0;
                hist.delete();
                chk("rd_n8_after", 32'(n8), 32'h0);
            end else begin
                send(8'($urandom), 1'b0);
                r = int'($urandom_range(0, 6));
                repeat (r) step();
                clear = 1'b1;
                step();
                clear = 1'b0;
                void'(sb.pop_back());
                hist.delete();
                chk("rclr_busy", 32'(busy8), 32'h0);
                chk("rclr_crc32", crc32, 32'h0);
            end
        end

        // Reset asserted mid-BUSY takes effect within the same cycle
        wait_idle();
        @(posedge clk);
        #1;
        send(8'($urandom), 1'b0);
        step();
        step();
        rst = 1'b1;
        #1;
        chk_init("mrst");
        chk("mrst_rdy8", 32'(rdy8), 32'h1);
        sb.delete();
        hist.delete();
        @(negedge clk);
        #1;
        rst   = 1'b0;
        ref_t = $time;
        send(8'($urandom), 1'b0);
        chk("mrst_accept_gap", 32'(acc_t - ref_t), 32'd4);
        wait_idle();

        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
